id_ex_stage: RTL

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/id_ex_stage_pkg.sv | 77 +++++++
 rtl/id_ex_stage_alu_ctrl_decode.sv | 106 ++++++++++
 rtl/id_ex_stage.sv | 120 ++++++++++++
 3 files changed

// File: rtl/id_ex_stage_pkg.sv
// rtl/id_ex_stage_pkg.sv - shared ALU codes, MIPS opcode/funct constants and pipeline bundles
package id_ex_stage_pkg;

  typedef enum logic [3:0] {
    ALU_NOP  = 4'h0,
    ALU_OR   = 4'h3,
    ALU_ADD  = 4'h4,
    ALU_AND  = 4'h5,
    ALU_SUB  = 4'h7,
    ALU_SLL  = 4'h8,
    ALU_SRL  = 4'h9,
    ALU_LUI  = 4'hB,
    ALU_SLT  = 4'hC,
    ALU_SLTU = 4'hD,
    ALU_NOR  = 4'hE,
    ALU_JR   = 4'hF
  } alu_op_e;

  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_BEQ   = 6'h04;
  localparam logic [5:0] OPC_ADDI  = 6'h08;
  localparam logic [5:0] OPC_ADDIU = 6'h09;
  localparam logic [5:0] OPC_SLTI  = 6'h0A;
  localparam logic [5:0] OPC_SLTIU = 6'h0B;
  localparam logic [5:0] OPC_ANDI  = 6'h0C;
  localparam logic [5:0] OPC_ORI   = 6'h0D;
  localparam logic [5:0] OPC_LUI   = 6'h0F;
  localparam logic [5:0] OPC_LW    = 6'h23;
  localparam logic [5:0] OPC_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  typedef struct packed {
    alu_op_e op;
    logic    regwrite;
    logic    memread;
    logic    memwrite;
    logic    branch;
  } ctrl_t;

  typedef enum logic {OP1_RS, OP1_RT} op1_sel_e;
  typedef enum logic [1:0] {OP2_RT, OP2_RS, OP2_IMM} op2_sel_e;

  typedef struct packed {
    logic        valid;
    ctrl_t       ctrl;
    logic [4:0]  rd;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  shamt;
    op1_sel_e    op1_sel;
    op2_sel_e    op2_sel;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm;
  } id_ex_t;

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

  function automatic logic [31:0] zext16(input logic [15:0] v);
    return {16'h0000, v};
  endfunction

endpackage

// File: rtl/id_ex_stage_alu_ctrl_decode.sv
// rtl/id_ex_stage_alu_ctrl_decode.sv - combinational instruction to ALU-control decode
module alu_ctrl_decode
  import id_ex_stage_pkg::*;
(
  input  logic [31:0] instr_i,
  output ctrl_t       ctrl_o,
  output logic [4:0]  rs_o,
  output logic [4:0]  rt_o,
  output logic [4:0]  rd_o,
  output logic [4:0]  shamt_o,
  output logic [31:0] imm_o,
  output op1_sel_e    op1_sel_o,
  output op2_sel_e    op2_sel_o,
  output logic        uses_rt_o
);

  logic [5:0] opcode;
  logic [5:0] funct;

  assign opcode = instr_i[31:26];
  assign funct  = instr_i[5:0];
  assign rs_o   = instr_i[25:21];
  assign rt_o   = instr_i[20:16];

  always_comb begin
    ctrl_o    = '0;
    rd_o      = instr_i[20:16];
    shamt_o   = 5'd0;
    imm_o     = sext16(instr_i[15:0]);
    op1_sel_o = OP1_RS;
    op2_sel_o = OP2_IMM;
    uses_rt_o = 1'b0;

    case (opcode)
      OPC_RTYPE: begin
        rd_o            = instr_i[15:11];
        op2_sel_o       = OP2_RT;
        uses_rt_o       = 1'b1;
        ctrl_o.regwrite = 1'b1;
        case (funct)
          FN_ADD, FN_ADDU: ctrl_o.op = ALU_ADD;
          FN_SUB, FN_SUBU: begin
            ctrl_o.op = ALU_SUB;
            op1_sel_o = OP1_RT;
            op2_sel_o = OP2_RS;
          end
          FN_AND: ctrl_o.op = ALU_AND;
          FN_OR:  ctrl_o.op = ALU_OR;
          FN_NOR: ctrl_o.op = ALU_NOR;
          FN_SLT: ctrl_o.op = ALU_SLT;
          FN_SLTU: ctrl_o.op = ALU_SLTU;
          FN_SLL, FN_SRL: begin
            ctrl_o.op = (funct == FN_SLL) ? ALU_SLL : ALU_SRL;
            shamt_o   = instr_i[10:6];
          end
          FN_JR: begin
            ctrl_o.op       = ALU_JR;
            op2_sel_o       = OP2_RS;
            ctrl_o.regwrite = 1'b0;
          end
          default: ctrl_o.regwrite = 1'b0;
        endcase
      end
      OPC_ADDI, OPC_ADDIU: begin
        ctrl_o.op       = ALU_ADD;
        ctrl_o.regwrite = 1'b1;
      end
      OPC_SLTI: begin
        ctrl_o.op       = ALU_SLT;
        ctrl_o.regwrite = 1'b1;
      end
      OPC_SLTIU: begin
        ctrl_o.op       = ALU_SLTU;
        ctrl_o.regwrite = 1'b1;
      end
      OPC_ANDI, OPC_ORI, OPC_LUI: begin
        ctrl_o.op       = (opcode == OPC_ANDI) ? ALU_AND :
                          (opcode == OPC_ORI)  ? ALU_OR  : ALU_LUI;
        imm_o           = zext16(instr_i[15:0]);
        ctrl_o.regwrite = 1'b1;
      end
      OPC_LW: begin
        ctrl_o.op       = ALU_ADD;
        ctrl_o.regwrite = 1'b1;
        ctrl_o.memread  = 1'b1;
      end
      OPC_SW: begin
        ctrl_o.op       = ALU_ADD;
        ctrl_o.memwrite = 1'b1;
        uses_rt_o       = 1'b1;
      end
      OPC_BEQ: begin
        // ALU computes Op2 - Op1, so swap to get rs - rt
        ctrl_o.op     = ALU_SUB;
        ctrl_o.branch = 1'b1;
        op1_sel_o     = OP1_RT;
        op2_sel_o     = OP2_RS;
        uses_rt_o     = 1'b1;
      end
      default: ;
    endcase

    if (rd_o == 5'd0) ctrl_o.regwrite = 1'b0;
  end

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with operand forwarding and load-use detect
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int FWD_EN = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] id_instr,
  input  logic        id_valid,
  input  logic [31:0] id_rs_data,
  input  logic [31:0] id_rt_data,
  input  logic        stall,
  input  logic        flush,
  input  logic [4:0]  mem_rd,
  input  logic [4:0]  wb_rd,
  input  logic        mem_regwrite,
  input  logic        wb_regwrite,
  input  logic [31:0] mem_fwd_data,
  input  logic [31:0] wb_fwd_data,
  output logic [31:0] EXE_Op1,
  output logic [31:0] EXE_Op2,
  output logic [3:0]  EXE_Operation,
  output logic [4:0]  EXE_Shamt,
  output logic [4:0]  EXE_Rd,
  output logic        EXE_RegWrite,
  output logic        EXE_MemRead,
  output logic        EXE_MemWrite,
  output logic        EXE_Branch,
  output logic        EXE_Valid,
  output logic        load_use_stall
);

  localparam logic FWD_ON = (FWD_EN != 0);

  ctrl_t       dec_ctrl;
  logic [4:0]  dec_rs, dec_rt, dec_rd, dec_shamt;
  logic [31:0] dec_imm;
  op1_sel_e    dec_op1_sel;
  op2_sel_e    dec_op2_sel;
  logic        dec_uses_rt;

  alu_ctrl_decode u_decode (
    .instr_i   (id_instr),
    .ctrl_o    (dec_ctrl),
    .rs_o      (dec_rs),
    .rt_o      (dec_rt),
    .rd_o      (dec_rd),
    .shamt_o   (dec_shamt),
    .imm_o     (dec_imm),
    .op1_sel_o (dec_op1_sel),
    .op2_sel_o (dec_op2_sel),
    .uses_rt_o (dec_uses_rt)
  );

  id_ex_t dec_s, ex_d, ex_q;

  always_comb begin
    dec_s         = '0;
    dec_s.valid   = 1'b1;
    dec_s.ctrl    = dec_ctrl;
    dec_s.rd      = dec_rd;
    dec_s.rs      = dec_rs;
    dec_s.rt      = dec_rt;
    dec_s.shamt   = dec_shamt;
    dec_s.op1_sel = dec_op1_sel;
    dec_s.op2_sel = dec_op2_sel;
    dec_s.rs_data = id_rs_data;
    dec_s.rt_data = id_rt_data;
    dec_s.imm     = dec_imm;
  end

  // flush outranks stall; an invalid ID slot becomes an all-zero bubble
  always_comb begin
    ex_d = ex_q;
    if (flush) begin
      ex_d = '0;
    end else if (!stall) begin
      if (id_valid) ex_d = dec_s;
      else          ex_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ex_q <= '0;
    else        ex_q <= ex_d;
  end

  function automatic logic [31:0] fwd(input logic [4:0] src, input logic [31:0] reg_data);
    if (FWD_ON && mem_regwrite && (mem_rd != 5'd0) && (mem_rd == src)) return mem_fwd_data;
    if (FWD_ON && wb_regwrite && (wb_rd != 5'd0) && (wb_rd == src))    return wb_fwd_data;
    return reg_data;
  endfunction

  logic [31:0] rs_val, rt_val;

  always_comb begin
    rs_val  = fwd(ex_q.rs, ex_q.rs_data);
    rt_val  = fwd(ex_q.rt, ex_q.rt_data);
    EXE_Op1 = (ex_q.op1_sel == OP1_RT) ? rt_val : rs_val;
    case (ex_q.op2_sel)
      OP2_RT:  EXE_Op2 = rt_val;
      OP2_RS:  EXE_Op2 = rs_val;
      default: EXE_Op2 = ex_q.imm;
    endcase
  end

  assign EXE_Operation = ex_q.ctrl.op;
  assign EXE_Shamt     = ex_q.shamt;
  assign EXE_Rd        = ex_q.rd;
  assign EXE_RegWrite  = ex_q.ctrl.regwrite;
  assign EXE_MemRead   = ex_q.ctrl.memread;
  assign EXE_MemWrite  = ex_q.ctrl.memwrite;
  assign EXE_Branch    = ex_q.ctrl.branch;
  assign EXE_Valid     = ex_q.valid;

  assign load_use_stall = ex_q.valid && ex_q.ctrl.memread && (ex_q.rd != 5'd0) && id_valid &&
                          ((ex_q.rd == dec_rs) || (dec_uses_rt && (ex_q.rd == dec_rt)));

endmodule
